// File: rtl/div32x32_seq.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock,
// start/busy/done handshake shared with the sequential multiplier.
module div32x32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_reg, d_reg;
  // R always stays below D, so its WIDTH+1-bit form has a zero MSB; only
  // the low WIDTH bits are kept.
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   r_shift, t_diff;
  logic [WIDTH-1:0] q_next, r_next;
  logic             last_iter;

  assign r_shift   = {r_reg, q_reg[WIDTH-1]};
  assign t_diff    = r_shift - {1'b0, d_reg};
  assign last_iter = (cnt == CNT_W'(WIDTH-1));
  assign q_next    = {q_reg[WIDTH-2:0], ~t_diff[WIDTH]};
  assign r_next    = t_diff[WIDTH] ? r_shift[WIDTH-1:0] : t_diff[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (b == '0) ? FIN : DIV;
      DIV: begin
        busy = 1'b1;
        if (last_iter) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (b == '0) begin
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
            end else begin
              q_reg <= a;
              d_reg <= b;
              r_reg <= '0;
              cnt   <= '0;
            end
          end
        end
        DIV: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32x32_seq.sv
// Directed bench for div32x32_seq: hand-computed quotients/remainders,
// latency, ignored starts, async reset mid-divide and back-to-back issue.
module tb_div32x32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  div32x32_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one divide, then watch until done (bounded) and check results.
  task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_z, input int exp_lat);
    int lat, busy_cnt;
    bit seen;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    start = 1'b1; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_cnt = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_quotient"}, quotient, exp_q);
    check({tag, "_remainder"}, remainder, exp_r);
    check({tag, "_dbz"}, div_by_zero, exp_z);
    @(negedge clk);
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int dones, first, prev, k;
    bit single;
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, 32'h0);
    check("rst_r", remainder, 32'h0);
    check("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk); reset = 1'b1;

    run_div("d100_7",  32'd100,        32'd7,          32'd14,         32'd2, 1'b0, 33);
    run_div("dmax_1",  32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0, 1'b0, 33);
    run_div("dmax_max",32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0, 1'b0, 33);
    run_div("d8000_3", 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2, 1'b0, 33);
    run_div("d5_0",    32'd5,          32'd0,          32'hFFFFFFFF,   32'd5, 1'b1, 1);
    run_div("d9_4",    32'd9,          32'd4,          32'd2,          32'd1, 1'b0, 33);

    // 3/10 with a second start attempted mid-divide
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0; first = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) first = i;
      end
      if (i == 10) begin
        start = 1'b1; a = 32'd50; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    check("ign_first_done", first, 33);
    check("ign_done_count", dones, 1);
    check("ign_quotient", quotient, 32'd0);
    check("ign_remainder", remainder, 32'd3);

    // start held high: accepted every 34 cycles
    @(negedge clk);
    start = 1'b1; a = 32'd20; b = 32'd6;
    dones = 0; first = 0; prev = 0; single = 1;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) first = i;
        else check("b2b_interval", i - prev, 34);
        prev = i;
        check("b2b_quotient", quotient, 32'd3);
        check("b2b_remainder", remainder, 32'd2);
      end else if (prev != 0 && i == prev + 1 && busy) begin
        single = 0;
      end
    end
    check("b2b_first_done", first, 33);
    check("b2b_done_count", dones, 3);
    check("b2b_single_pulse", single, 1'b1);
    start = 1'b0;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("b2b_drain", busy, 1'b0);

    // async reset in the middle of 1000/3
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    check("mid_rst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    check("mid_rst_hold", {busy, done}, 2'b00);
    reset = 1'b1;
    run_div("d1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div32x32_seq.md
Name: div32x32_seq

Overview:
- Sequential unsigned divider: the inverse-direction companion to the team's 32x32 sequential multiplier.
- Same start/busy control style as the multiplier, so the two can share an issue slot in the arithmetic unit.
- Radix-2 restoring algorithm producing one quotient bit per clock.
- Produces quotient and remainder registers plus a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (power of two, >= 4).
- CNT_W, $clog2(WIDTH), iteration-counter width (derived, not to be overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  dividend; sampled on the accepting edge only.
- b  input  WIDTH  divisor; sampled on the accepting edge only.
- busy  output  1  high while an iteration sequence is in progress.
- done  output  1  one-cycle pulse: results valid.
- quotient  output  WIDTH  a / b (unsigned).
- remainder  output  WIDTH  a % b (unsigned).
- div_by_zero  output  1  set with done when the captured b == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - busy, done, div_by_zero, quotient, remainder, counter and working registers all 0.
  - Takes effect immediately, including mid-division; the in-flight operation is abandoned with no done.
- States: IDLE, DIV, FIN.
- IDLE, start=1, b!=0 (edge E0):
  - Capture a into working dividend/quotient shift register Q and b into divisor register D.
  - Clear partial remainder R (WIDTH+1 bits); counter=0; next=DIV.
- IDLE, start=1, b==0 (edge E0):
  - No iterations; next=FIN.
  - Load result quotient={WIDTH{1}}, remainder=a, div_by_zero=1.
- IDLE, start=0: hold; outputs unchanged.
- DIV, each edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}.
  - If T is non-negative (T[WIDTH]==0): R=T, Q={Q[WIDTH-2:0],1}.
  - Else: R={R[WIDTH-1:0], Q[WIDTH-1]}, Q={Q[WIDTH-2:0],0}.
  - counter++. On the edge where counter==WIDTH-1, next=FIN.
  - That same edge loads quotient=final Q, remainder=final R[WIDTH-1:0], div_by_zero=0.
- FIN: one cycle, then next=IDLE.
- busy: combinational from state; 1 in DIV and FIN, 0 in IDLE.
- done: combinational, 1 exactly in FIN.
- Latency, normal divide:
  - start accepted at E0; iterations on E1..E32.
  - done=1 in the cycle after E32, i.e. 33 cycles after E0.
  - busy high for 33 cycles.
- Latency, divide by zero: done=1 in the cycle after E0; busy high 1 cycle.
- start while busy=1: ignored. a and b changes while busy have no effect.
- Back-to-back: a start asserted in the FIN cycle is ignored. The earliest accepted restart is the cycle after FIN, when busy=0.
- Result holding:
  - quotient, remainder and div_by_zero hold their values until the next completion or reset.
  - A new accepted start does not clear them.
  - div_by_zero is cleared by the next successful completion.
- Arithmetic: unsigned only. a < b yields quotient 0, remainder a. No overflow is possible for b != 0.

Test Plan:
- Reset low, then high; start a=100, b=7 -> busy rises next cycle; done pulses 33 cycles after the accepting edge; quotient=14, remainder=2, div_by_zero=0.
- a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0. Then a=0xFFFFFFFF, b=0xFFFFFFFF -> quotient=1, remainder=0. Then a=0x80000000, b=3 -> quotient=0x2AAAAAAA, remainder=2.
- a=5, b=0 -> done one cycle after accept, busy high 1 cycle, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Then 9/4 -> quotient=2, remainder=1, div_by_zero=0.
- a=3, b=10 -> quotient=0, remainder=3. Start asserted with a=50, b=5 at cycle 10 of busy -> ignored; result still 0/3; no extra done.
- Start 1000/3; drive reset low at iteration 15 -> all outputs 0 immediately; after release, start 1000/3 again -> quotient=333, remainder=1 after 33 cycles.
- Hold start high continuously with 20/6 -> ops accepted every 34 cycles (restart the cycle after FIN); each returns quotient=3, remainder=2; done pulses exactly one cycle each.
